dsp_issue_ctrl: RTL and testbench

Operand issue controller directly upstream of `DSP_top`. Buffers operand/configuration words from a valid/ready stream in a small FIFO and drives the DSP's `start`, `mode`, `mac`, `aa`, `bb`, `cc` inputs. It enforces the per-mode minimum issue interval and drains the DSP pipeline before any `mode`/`mac` change, so the DSP never sees an illegal start pattern.

---
 rtl/dsp_issue_ctrl_if.sv | 32 +++
 rtl/dsp_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dsp_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_issue_ctrl_if.sv
// Operand stream and DSP issue bus for dsp_issue_ctrl.
// The master side is the producer of operand words and the consumer of the DSP-side outputs.
interface dsp_issue_ctrl_if #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic             in_mac;
    logic [N-1:0]     in_aa;
    logic [M-1:0]     in_bb;
    logic [N+M-1:0]   in_cc;
    logic             start;
    logic [1:0]       mode;
    logic             mac;
    logic [N-1:0]     aa;
    logic [M-1:0]     bb;
    logic [N+M-1:0]   cc;
    logic             busy;
    logic             err_mode;

    modport master (
        output in_valid, in_mode, in_mac, in_aa, in_bb, in_cc,
        input  in_ready, start, mode, mac, aa, bb, cc, busy, err_mode
    );

    modport slave (
        input  in_valid, in_mode, in_mac, in_aa, in_bb, in_cc,
        output in_ready, start, mode, mac, aa, bb, cc, busy, err_mode
    );
endinterface

// File: rtl/dsp_issue_ctrl.sv
// Operand issue controller in front of DSP_top.
// Buffers operand words in a FIFO and issues them with the per-mode minimum
// interval, draining the DSP pipeline before any mode/mac change.
// Optional: define DSP_ISSUE_SIGNEXT_EN to sign-extend the upper halves of
// aa (modes 0/1) and bb (mode 0) from their midpoint bit at issue.
module dsp_issue_ctrl #(
    parameter int unsigned N     = 32,
    parameter int unsigned M     = 32,
    parameter int unsigned PIPES = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    dsp_issue_ctrl_if.slave bus
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam int unsigned W         = 2 * (N + M) + 3;
    localparam int unsigned DRAIN_MAX = 4 + PIPES + 2;
    localparam int unsigned GW        = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;

    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    state_t         state;
    logic [1:0]     gap_cnt;
    logic [GW-1:0]  age;
    logic [GW-1:0]  drain_lim;
    logic           have_cfg;

    logic [W-1:0]   head;
    logic [1:0]     head_mode;
    logic           head_mac;
    logic [N-1:0]   head_aa;
    logic [M-1:0]   head_bb;
    logic [N+M-1:0] head_cc;
    logic [N-1:0]   issue_aa;
    logic [M-1:0]   issue_bb;
    logic [2:0]     new_int;

    logic wr_en;
    logic bad_word;
    logic cfg_match;
    logic issue;
    logic gap_nxt;

    // Minimum start-to-start interval for a given DSP mode.
    function automatic logic [2:0] int_of(input logic [1:0] md);
        case (md)
            2'd0:    int_of = 3'd1;
            2'd1:    int_of = 3'd2;
            default: int_of = 3'd4;
        endcase
    endfunction

    // Head-of-queue field split.
    always_comb begin
        head      = mem[rd_ptr];
        head_cc   = head[N+M-1:0];
        head_bb   = head[N+2*M-1:N+M];
        head_aa   = head[2*N+2*M-1:N+2*M];
        head_mac  = head[2*N+2*M];
        head_mode = head[2*N+2*M+2:2*N+2*M+1];
    end

    // Issue decision: same config issues freely, a new config waits out the drain window.
    always_comb begin
        wr_en     = bus.in_valid && bus.in_ready && (bus.in_mode != 2'd3);
        bad_word  = bus.in_valid && bus.in_ready && (bus.in_mode == 2'd3);
        cfg_match = !have_cfg || ((head_mode == bus.mode) && (head_mac == bus.mac));
        drain_lim = GW'(int_of(bus.mode)) + GW'(PIPES + 2);
        issue     = (cnt != '0) && (state != GAP) && (cfg_match || (age >= drain_lim));
        cnt_nxt   = cnt + CW'(wr_en) - CW'(issue);
        new_int   = int_of(head_mode);
        gap_nxt   = (issue && (new_int != 3'd1)) || ((state == GAP) && (gap_cnt != 2'd0));
    end

    // Operand shaping applied at issue time.
    always_comb begin
        issue_aa = head_aa;
        issue_bb = head_bb;
`ifdef DSP_ISSUE_SIGNEXT_EN
        if ((head_mode == 2'd0) || (head_mode == 2'd1)) begin
            for (int i = int'(N / 2) + 1; i < int'(N); i++) begin
                issue_aa[i] = head_aa[N/2];
            end
        end
        if (head_mode == 2'd0) begin
            for (int i = int'(M / 2) + 1; i < int'(M); i++) begin
                issue_bb[i] = head_bb[M/2];
            end
        end
`endif
    end

    // FIFO storage; mode-3 words never get written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.in_mode, bus.in_mac, bus.in_aa, bus.in_bb, bus.in_cc};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt_nxt;
        end
    end

    // Issue FSM with registered DSP-side outputs and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gap_cnt      <= 2'd0;
            age          <= GW'(DRAIN_MAX);
            have_cfg     <= 1'b0;
            bus.start    <= 1'b0;
            bus.mode     <= 2'd0;
            bus.mac      <= 1'b0;
            bus.aa       <= '0;
            bus.bb       <= '0;
            bus.cc       <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
            bus.err_mode <= 1'b0;
        end else begin
            bus.start    <= issue;
            bus.in_ready <= (cnt_nxt != CW'(DEPTH));
            bus.busy     <= (cnt_nxt != '0) || gap_nxt;
            if (bad_word) bus.err_mode <= 1'b1;

            if (issue) begin
                age <= GW'(1);
            end else if (age < GW'(DRAIN_MAX)) begin
                age <= age + GW'(1);
            end

            if (issue) begin
                have_cfg <= 1'b1;
                bus.mode <= head_mode;
                bus.mac  <= head_mac;
                bus.aa   <= issue_aa;
                bus.bb   <= issue_bb;
                bus.cc   <= head_cc;
            end

            case (state)
                IDLE, ISSUE, DRAIN: begin
                    if (issue) begin
                        if (new_int == 3'd1) begin
                            state <= (cnt_nxt != '0) ? ISSUE : IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 2'(new_int - 3'd2);
                        end
                    end else if (cnt != '0) begin
                        state <= DRAIN;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt != 2'd0) begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end else begin
                        state <= (cnt_nxt != '0) ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Bench for dsp_issue_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based timing model.
module tb_dsp_issue_ctrl;
    localparam int N     = 32;
    localparam int M     = 32;
    localparam int PIPES = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]     md;
        logic           mc;
        logic [N-1:0]   a;
        logic [M-1:0]   b;
        logic [N+M-1:0] c;
    } word_t;

    logic clk;
    logic rst;

    dsp_issue_ctrl_if #(.N(N), .M(M)) bus ();

    dsp_issue_ctrl #(.N(N), .M(M), .PIPES(PIPES), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    word_t          q[$];
    int             cyc = 0;
    int             last_t = 0;
    bit             have = 0;
    logic [1:0]     l_mode = 0;
    logic           l_mac = 0;
    logic           m_ready = 0;
    logic           m_err = 0;
    logic           e_start = 0;
    logic           e_busy = 0;
    word_t          e_out = '0;

    // Observation records
    int             st_q[$];
    logic [N-1:0]   sa_q[$];
    bit             rdy_low;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int intv(input logic [1:0] md);
        if (md == 2'd0) return 1;
        if (md == 2'd1) return 2;
        return 4;
    endfunction

    function automatic word_t shape(input word_t w);
        word_t r;
        r = w;
`ifdef DSP_ISSUE_SIGNEXT_EN
        if (w.md != 2'd2) r.a = {{(N/2-1){w.a[N/2]}}, w.a[N/2:0]};
        if (w.md == 2'd0) r.b = {{(M/2-1){w.b[M/2]}}, w.b[M/2:0]};
`endif
        return r;
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_edge();
        word_t w;
        int    lim;
        bit    ok;
        cyc++;
        if (rst) begin
            q.delete();
            have    = 0;
            m_ready = 0;
            m_err   = 0;
            e_start = 0;
            e_busy  = 0;
            e_out   = '0;
            return;
        end
        e_start = 0;
        if (q.size() != 0) begin
            ok = 1;
            if (have) begin
                lim = last_t + intv(l_mode);
                if (q[0].md != l_mode || q[0].mc != l_mac) lim += PIPES + 2;
                ok = (cyc >= lim);
            end
            if (ok) begin
                w       = shape(q.pop_front());
                e_start = 1;
                e_out   = w;
                last_t  = cyc;
                have    = 1;
                l_mode  = w.md;
                l_mac   = w.mc;
            end
        end
        if (bus.in_valid && m_ready) begin
            if (bus.in_mode == 2'd3) begin
                m_err = 1;
            end else begin
                w.md = bus.in_mode;
                w.mc = bus.in_mac;
                w.a  = bus.in_aa;
                w.b  = bus.in_bb;
                w.c  = bus.in_cc;
                q.push_back(w);
            end
        end
        m_ready = (q.size() < DEPTH);
        e_busy  = (q.size() != 0) || (have && (cyc - last_t) <= intv(l_mode) - 2);
    endtask

    task automatic compare_all();
        if (bus.start === 1'b1) begin
            st_q.push_back(cyc);
            sa_q.push_back(bus.aa);
        end
        if (bus.in_ready !== 1'b1) rdy_low = 1;
        check_eq("start",    bus.start,    e_start);
        check_eq("mode",     bus.mode,     e_out.md);
        check_eq("mac",      bus.mac,      e_out.mc);
        check_eq("aa",       bus.aa,       e_out.a);
        check_eq("bb",       bus.bb,       e_out.b);
        check_eq("cc",       bus.cc,       e_out.c);
        check_eq("in_ready", bus.in_ready, m_ready);
        check_eq("busy",     bus.busy,     e_busy);
        check_eq("err_mode", bus.err_mode, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Present one word and hold it until the handshake completes; returns accept cycle.
    task automatic send(input logic [1:0] md, input logic mc, input logic [N-1:0] a, output int acc);
        bit accepted;
        bus.in_valid = 1'b1;
        bus.in_mode  = md;
        bus.in_mac   = mc;
        bus.in_aa    = a;
        bus.in_bb    = M'(a) ^ 32'h5a5a_0f0f;
        bus.in_cc    = {a, ~a};
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            accepted = m_ready;
            tick();
            if (accepted) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check_eq("send_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            acc;
        int            acc0;
        logic [1:0]    cur_mode;
        logic          cur_mac;
        logic [N-1:0]  sx_exp;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'd0;
        bus.in_mac   = 1'b0;
        bus.in_aa    = '0;
        bus.in_bb    = '0;
        bus.in_cc    = '0;
        do_reset(3);
        idle(1);

        // Four mode-0 words back to back
        st_q.delete(); sa_q.delete();
        send(2'd0, 1'b0, 32'd1, acc0);
        send(2'd0, 1'b0, 32'd2, acc);
        send(2'd0, 1'b0, 32'd3, acc);
        send(2'd0, 1'b0, 32'd4, acc);
        idle(4);
        check_eq("b2b_count", st_q.size(), 4);
        if (st_q.size() == 4) begin
            check_eq("b2b_latency", st_q[0] - acc0, 1);
            check_eq("b2b_span",    st_q[3] - st_q[0], 3);
            for (int i = 0; i < 4; i++) check_eq("b2b_aa", sa_q[i], i + 1);
        end

        // Three mode-2 words: pulses four cycles apart, no backpressure
        idle(10);
        st_q.delete(); rdy_low = 0;
        for (int i = 0; i < 3; i++) send(2'd2, 1'b0, N'(10 + i), acc);
        idle(16);
        check_eq("m2_count", st_q.size(), 3);
        if (st_q.size() == 3) begin
            check_eq("m2_gap0", st_q[1] - st_q[0], 4);
            check_eq("m2_gap1", st_q[2] - st_q[1], 4);
        end
        check_eq("m2_ready_held", rdy_low, 1'b0);

        // Mode change 0 -> 2 drains INT(0)+PIPES+2 cycles
        st_q.delete();
        send(2'd0, 1'b0, 32'd20, acc);
        send(2'd2, 1'b0, 32'd21, acc);
        idle(14);
        check_eq("drain_mode_count", st_q.size(), 2);
        if (st_q.size() == 2) check_eq("drain_mode_gap", st_q[1] - st_q[0], 5);

        // mac change 0 -> 1 with mode 0 unchanged
        st_q.delete();
        send(2'd0, 1'b0, 32'd22, acc);
        send(2'd0, 1'b1, 32'd23, acc);
        idle(14);
        check_eq("drain_mac_count", st_q.size(), 2);
        if (st_q.size() == 2) check_eq("drain_mac_gap", st_q[1] - st_q[0], 5);

        // Six mode-2 words under stall: backpressure, order kept
        st_q.delete(); sa_q.delete(); rdy_low = 0;
        for (int i = 0; i < 6; i++) send(2'd2, 1'b1, N'(100 + i), acc);
        idle(40);
        check_eq("stall_ready_dropped", rdy_low, 1'b1);
        check_eq("stall_count", st_q.size(), 6);
        if (st_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check_eq("stall_order", sa_q[i], N'(100 + i));
        end

        // Illegal mode word between two legal ones
        st_q.delete();
        send(2'd0, 1'b0, 32'd7, acc);
        send(2'd3, 1'b0, 32'd99, acc);
        send(2'd0, 1'b0, 32'd8, acc);
        idle(12);
        check_eq("err_starts", st_q.size(), 2);
        check_eq("err_sticky", bus.err_mode, 1'b1);
        do_reset(1);
        check_eq("err_cleared", bus.err_mode, 1'b0);
        check_eq("rst_aa", bus.aa, 32'd0);
        check_eq("rst_ready_low", bus.in_ready, 1'b0);
        idle(1);
        check_eq("ready_after_rst", bus.in_ready, 1'b1);

        // Sign-extension boundary word
        st_q.delete(); sa_q.delete();
        send(2'd0, 1'b0, 32'h0001_8000, acc);
        idle(3);
`ifdef DSP_ISSUE_SIGNEXT_EN
        sx_exp = 32'hFFFF_8000;
`else
        sx_exp = 32'h0001_8000;
`endif
        check_eq("signext_count", st_q.size(), 1);
        if (sa_q.size() == 1) check_eq("signext_aa", sa_q[0], sx_exp);

        // Reset while in GAP with words queued
        send(2'd2, 1'b0, 32'd30, acc);
        send(2'd2, 1'b0, 32'd31, acc);
        send(2'd2, 1'b0, 32'd32, acc);
        do_reset(1);
        st_q.delete();
        idle(8);
        check_eq("rst_gap_dropped", st_q.size(), 0);
        check_eq("rst_gap_busy", bus.busy, 1'b0);

        // Random traffic against the model
        cur_mode = 2'd0;
        cur_mac  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 9) == 0) cur_mode = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 11) == 0) cur_mac = ~cur_mac;
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_mode  = ($urandom_range(0, 39) == 0) ? 2'd3 : cur_mode;
            bus.in_mac   = cur_mac;
            bus.in_aa    = $urandom;
            bus.in_bb    = $urandom;
            bus.in_cc    = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        idle(30);
        check_eq("final_idle", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
